// File: rtl/burst_mem_ctrl_pkg.sv
// Shared state encoding and parity helper for the burst memory controller.
package burst_mem_ctrl_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WRITE, READ} stateT;

    // Callers zero-extend their word; padding zeros leave the XOR unchanged.
    localparam int PAR_MAX_W = 1024;

    function automatic logic evenParity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Single-port storage: synchronous write, registered read with one-cycle latency.
module burst_mem_array #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wData,
    output logic [WORD_W-1:0] rData
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wData;
        end
    end

    // Read register holds its value between beats so RdData stays stable.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rData <= '0;
        end else if (re) begin
            rData <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_mem_ctrl.sv
// Clocked burst memory controller with post-reset clear sweep and address wrap.
// Optional stored even parity with injection is enabled by defining PARITY_EN.
module burst_mem_ctrl
    import burst_mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int BURST_W = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Req,
    output logic               Ready,
    input  logic               MemWr,
    input  logic [ADDR_W-1:0]  Addr,
    input  logic [BURST_W-1:0] BurstLen,
    input  logic [DATA_W-1:0]  WrData,
    input  logic               WrValid,
    output logic               WrReady,
    output logic [DATA_W-1:0]  RdData,
    output logic               RdValid,
    output logic               Done,
    output logic               AddrErr,
    output logic               Busy
`ifdef PARITY_EN
    ,
    input  logic               ParityInj,
    output logic               ParityErr
`endif
);

    localparam int CNT_W = BURST_W + 1;
`ifdef PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  ONE_BEAT  = CNT_W'(1);

    stateT             state, nextState;
    logic [ADDR_W-1:0] ptr, ptrNext, ptrInc;
    logic [CNT_W-1:0]  beats, beatsNext;
    logic              doneSet, errSet, memWe, memRe, addrBad;
    logic [WORD_W-1:0] memWData, memRData, wrWord;
    logic              rdVld_p1;

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    assign ptrInc  = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    assign addrBad = (ADDR_W+1)'(Addr) >= (ADDR_W+1)'(DEPTH);

`ifdef PARITY_EN
    assign wrWord = {evenParity(PAR_MAX_W'(WrData)) ^ ParityInj, WrData};
`else
    assign wrWord = WrData;
`endif

    always_comb begin
        nextState = state;
        ptrNext   = ptr;
        beatsNext = beats;
        doneSet   = 1'b0;
        errSet    = 1'b0;
        memWe     = 1'b0;
        memRe     = 1'b0;
        memWData  = '0;
        Ready     = 1'b0;
        WrReady   = 1'b0;
        case (state)
            INIT: begin
                memWe   = 1'b1;
                ptrNext = ptrInc;
                if (ptr == LAST_ADDR) begin
                    nextState = IDLE;
                end
            end
            IDLE: begin
                Ready = 1'b1;
                if (Req) begin
                    ptrNext   = Addr;
                    beatsNext = {1'b0, BurstLen} + ONE_BEAT;
                    if (addrBad) begin
                        errSet  = 1'b1;
                        doneSet = 1'b1;
                    end else begin
                        nextState = MemWr ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                WrReady = 1'b1;
                if (WrValid) begin
                    memWe     = 1'b1;
                    memWData  = wrWord;
                    ptrNext   = ptrInc;
                    beatsNext = beats - ONE_BEAT;
                    if (beats == ONE_BEAT) begin
                        nextState = IDLE;
                        doneSet   = 1'b1;
                    end
                end
            end
            READ: begin
                memRe     = 1'b1;
                ptrNext   = ptrInc;
                beatsNext = beats - ONE_BEAT;
                if (beats == ONE_BEAT) begin
                    nextState = IDLE;
                    doneSet   = 1'b1;
                end
            end
            default: nextState = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= INIT;
            ptr      <= '0;
            beats    <= '0;
            Done     <= 1'b0;
            AddrErr  <= 1'b0;
            rdVld_p1 <= 1'b0;
        end else begin
            state    <= nextState;
            ptr      <= ptrNext;
            beats    <= beatsNext;
            Done     <= doneSet;
            AddrErr  <= errSet;
            rdVld_p1 <= memRe;
        end
    end

    // Stage p1: array output register, aligned with rdVld_p1.
    assign RdValid = rdVld_p1;
    assign RdData  = memRData[DATA_W-1:0];
    assign Busy    = (state != IDLE);

`ifdef PARITY_EN
    assign ParityErr = rdVld_p1 &&
                       (evenParity(PAR_MAX_W'(memRData[DATA_W-1:0])) != memRData[DATA_W]);
`endif

    burst_mem_array #(
        .WORD_W(WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) uArray (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .we   (memWe),
        .re   (memRe),
        .addr (ptr),
        .wData(memWData),
        .rData(memRData)
    );

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed bench for burst_mem_ctrl: one DEPTH=64 instance and one DEPTH=48 instance.
module tb_burst_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstN, req, ready, memWr, wrValid, wrReady, rdValid, done, addrErr, busy;
    logic [1:0][5:0]  addr;
    logic [1:0][3:0]  burstLen;
    logic [1:0][63:0] wrData, rdData;
`ifdef PARITY_EN
    logic [1:0]       parityInj, parityErr;
`endif

    int nChk = 0;
    int nBad = 0;
    logic [63:0] vec [16];

    burst_mem_ctrl #(.DATA_W(64), .DEPTH(64), .BURST_W(4)) dut64 (
        .Clk(clk), .Rst_n(rstN[0]), .Req(req[0]), .Ready(ready[0]), .MemWr(memWr[0]),
        .Addr(addr[0]), .BurstLen(burstLen[0]), .WrData(wrData[0]), .WrValid(wrValid[0]),
        .WrReady(wrReady[0]), .RdData(rdData[0]), .RdValid(rdValid[0]), .Done(done[0]),
        .AddrErr(addrErr[0]), .Busy(busy[0])
`ifdef PARITY_EN
        , .ParityInj(parityInj[0]), .ParityErr(parityErr[0])
`endif
    );

    burst_mem_ctrl #(.DATA_W(64), .DEPTH(48), .BURST_W(4)) dut48 (
        .Clk(clk), .Rst_n(rstN[1]), .Req(req[1]), .Ready(ready[1]), .MemWr(memWr[1]),
        .Addr(addr[1]), .BurstLen(burstLen[1]), .WrData(wrData[1]), .WrValid(wrValid[1]),
        .WrReady(wrReady[1]), .RdData(rdData[1]), .RdValid(rdValid[1]), .Done(done[1]),
        .AddrErr(addrErr[1]), .Busy(busy[1])
`ifdef PARITY_EN
        , .ParityInj(parityInj[1]), .ParityErr(parityErr[1])
`endif
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] expv);
        nChk++;
        if (got !== expv) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    task automatic checkResetVals(input int d);
        checkVal("rstReady",   64'(ready[d]),   0);
        checkVal("rstWrReady", 64'(wrReady[d]), 0);
        checkVal("rstRdValid", 64'(rdValid[d]), 0);
        checkVal("rstRdData",  rdData[d],       0);
        checkVal("rstDone",    64'(done[d]),    0);
        checkVal("rstAddrErr", 64'(addrErr[d]), 0);
        checkVal("rstBusy",    64'(busy[d]),    1);
    endtask

    // Asserts reset from a falling edge, checks outputs at once, then times INIT.
    task automatic resetDut(input int d, input int depthExp);
        int cnt = 0;
        rstN[d] = 1'b0;
        #1;
        checkResetVals(d);
        req[d]     = 1'b0;
        wrValid[d] = 1'b0;
        @(negedge clk);
        rstN[d] = 1'b1;
        while (busy[d] && !ready[d] && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        checkVal("initLen",   64'(cnt),       64'(depthExp));
        checkVal("initReady", 64'(ready[d]),  1);
        checkVal("initBusy",  64'(busy[d]),   0);
    endtask

    task automatic doCmd(input int d, input logic wr, input logic [5:0] a, input logic [3:0] bl);
        int guard = 0;
        while (!ready[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready[d]) begin
            checkVal("readyTimeout", 64'(ready[d]), 1);
            return;
        end
        req[d]      = 1'b1;
        memWr[d]    = wr;
        addr[d]     = a;
        burstLen[d] = bl;
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic readBurst(input int d, input logic [5:0] a, input logic [3:0] bl,
                             input logic [63:0] expv [16]);
        doCmd(d, 1'b0, a, bl);
        checkVal("rdLatency", 64'(rdValid[d]), 0);
        checkVal("rdBusy",    64'(busy[d]),    1);
        for (int i = 0; i <= int'(bl); i++) begin
            @(negedge clk);
            checkVal("rdValid", 64'(rdValid[d]), 1);
            checkVal("rdData",  rdData[d],       expv[i]);
            checkVal("rdDone",  64'(done[d]),    64'(i == int'(bl)));
            checkVal("rdReady", 64'(ready[d]),   64'(i == int'(bl)));
        end
        @(negedge clk);
        checkVal("rdAfter", 64'(rdValid[d]), 0);
    endtask

    task automatic writeBurst(input int d, input logic [5:0] a, input logic [3:0] bl,
                              input logic [63:0] dat [16], input int stallAt);
        doCmd(d, 1'b1, a, bl);
        for (int i = 0; i <= int'(bl); i++) begin
            if (i == stallAt) begin
                wrValid[d] = 1'b0;
                repeat (2) @(negedge clk);
                checkVal("wrStallReady", 64'(wrReady[d]), 1);
                checkVal("wrStallDone",  64'(done[d]),    0);
            end
            wrValid[d] = 1'b1;
            wrData[d]  = dat[i];
            @(negedge clk);
            if (i < int'(bl)) checkVal("wrEarlyDone", 64'(done[d]), 0);
        end
        wrValid[d] = 1'b0;
        checkVal("wrDone",  64'(done[d]),  1);
        checkVal("wrReady", 64'(ready[d]), 1);
        checkVal("wrBusy",  64'(busy[d]),  0);
    endtask

    task automatic readAllZero(input int d, input int words);
        vec = '{default: '0};
        for (int b = 0; b < words; b += 16) readBurst(d, 6'(b), 4'd15, vec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1);
    end

    initial begin
        rstN = '0; req = '0; memWr = '0; wrValid = '0;
        addr = '0; burstLen = '0; wrData = '0;
`ifdef PARITY_EN
        parityInj = '0;
`endif
        @(negedge clk);
        resetDut(0, 64);
        readAllZero(0, 64);

        vec = '{default: '0};
        vec[0] = 64'hAAAA_AAAA_AAAA_AAAA; vec[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        vec[2] = 64'hCCCC_CCCC_CCCC_CCCC; vec[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        writeBurst(0, 6'h05, 4'd3, vec, 2);
        readBurst(0, 6'h05, 4'd3, vec);

        vec = '{default: '0};
        vec[0] = 64'd1; vec[1] = 64'd2; vec[2] = 64'd3; vec[3] = 64'd4;
        writeBurst(0, 6'h3E, 4'd3, vec, -1);
        readBurst(0, 6'h3E, 4'd3, vec);
        vec = '{default: '0};
        vec[0] = 64'd3; vec[1] = 64'd4;
        readBurst(0, 6'h00, 4'd1, vec);

        // Abort an 8-beat write after three beats; WrValid stays high into reset.
        doCmd(0, 1'b1, 6'h20, 4'd7);
        for (int i = 0; i < 3; i++) begin
            wrValid[0] = 1'b1;
            wrData[0]  = 64'hFEED_0000_0000_0000 + 64'(i);
            @(negedge clk);
        end
        resetDut(0, 64);
        readAllZero(0, 64);

`ifdef PARITY_EN
        vec = '{default: '0};
        vec[0] = 64'h5;
        parityInj[0] = 1'b1;
        writeBurst(0, 6'h10, 4'd0, vec, -1);
        parityInj[0] = 1'b0;
        vec[0] = 64'h7;
        writeBurst(0, 6'h11, 4'd0, vec, -1);
        doCmd(0, 1'b0, 6'h10, 4'd1);
        @(negedge clk);
        checkVal("parValid0", 64'(rdValid[0]),   1);
        checkVal("parData0",  rdData[0],         64'h5);
        checkVal("parErrInj", 64'(parityErr[0]), 1);
        @(negedge clk);
        checkVal("parData1",  rdData[0],         64'h7);
        checkVal("parErrOk",  64'(parityErr[0]), 0);
        @(negedge clk);
        checkVal("parIdle",   64'(parityErr[0]), 0);
`endif

        resetDut(1, 48);
        vec = '{default: '0};
        vec[0] = 64'h11; vec[1] = 64'h22;
        writeBurst(1, 6'd47, 4'd1, vec, -1);
        readBurst(1, 6'd47, 4'd1, vec);
        vec = '{default: '0};
        vec[0] = 64'h22;
        readBurst(1, 6'd0, 4'd0, vec);

        doCmd(1, 1'b0, 6'd50, 4'd3);
        checkVal("errPulse",   64'(addrErr[1]), 1);
        checkVal("errDone",    64'(done[1]),    1);
        checkVal("errRdValid", 64'(rdValid[1]), 0);
        checkVal("errReady",   64'(ready[1]),   1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("errClear",  64'(addrErr[1]), 0);
            checkVal("errNoDone", 64'(done[1]),    0);
            checkVal("errNoRd",   64'(rdValid[1]), 0);
        end
        wrValid[1] = 1'b1;
        wrData[1]  = 64'hDEAD_BEEF_DEAD_BEEF;
        doCmd(1, 1'b1, 6'd50, 4'd0);
        checkVal("errWrPulse", 64'(addrErr[1]), 1);
        checkVal("errWrReady", 64'(wrReady[1]), 0);
        wrValid[1] = 1'b0;
        vec = '{default: '0};
        vec[0] = 64'h11; vec[1] = 64'h22;
        readBurst(1, 6'd47, 4'd1, vec);

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end

endmodule

// File: doc/burst_mem_ctrl.md
Name: burst_mem_ctrl

Overview:
Parametrised synchronous successor to the asynchronous 64x64 MemRd/MemWr/DataBus memory. It is a clocked single-port memory with a command handshake, single or burst read/write with address auto-increment and wrap, and a hardware clear sweep after reset. The tristate DataBus is split into separate write and read buses. It sits between a bus master and the storage array.

Parameters:
DATA_W, 64, word width in bits
DEPTH, 64, number of words; any value >= 2
ADDR_W, $clog2(DEPTH), address width
BURST_W, 4, width of BurstLen; max burst = 2**BURST_W beats

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Req  in  1  command request
Ready  out  1  command accept; command transfers when Req && Ready
MemWr  in  1  command type, sampled at accept: 1 = write, 0 = read
Addr  in  ADDR_W  start address, sampled at accept
BurstLen  in  BURST_W  beats minus 1, sampled at accept
WrData  in  DATA_W  write beat data
WrValid  in  1  write beat valid
WrReady  out  1  write beat accept; a beat transfers when WrValid && WrReady
RdData  out  DATA_W  read data, registered
RdValid  out  1  RdData valid, one cycle per beat; no backpressure
Done  out  1  one-cycle pulse at command completion
AddrErr  out  1  one-cycle pulse when the start Addr is >= DEPTH
Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=INIT, ptr=0. Outputs: Ready=0, WrReady=0, RdValid=0, RdData=0, Done=0, AddrErr=0, Busy=1.
- INIT: writes 0 to Mem[ptr] each cycle, ptr 0..DEPTH-1. After the write to DEPTH-1, state goes to IDLE, so INIT lasts exactly DEPTH cycles. Req is ignored.
- IDLE: Ready=1.
  - On accept: ptr=Addr, beats=BurstLen+1.
  - Next state is WRITE if MemWr=1, otherwise READ.
  - If Addr >= DEPTH: AddrErr and Done pulse in the next cycle, no memory access, and state returns to IDLE.
- WRITE: WrReady=1.
  - Each accepted beat writes Mem[ptr] <= WrData, then ptr advances and beats decrements.
  - WrValid=0 stalls the burst indefinitely.
  - The cycle after the last beat: Done=1, state=IDLE, Ready=1.
- READ: one array read per cycle, no stalls.
  - Command accepted at cycle T: reads are issued at T+1..T+N.
  - RdValid/RdData appear at T+2..T+N+1 (one-cycle array latency).
  - Done pulses with the last RdValid; Ready returns to 1 in that same cycle.
- Address wrap: after DEPTH-1, ptr goes to 0. This must be correct for non-power-of-two DEPTH (explicit compare, not truncation).
- Non-IDLE states: Ready=0, so Req is ignored. WrValid outside WRITE is ignored. RdData holds its last value when RdValid=0.
- Reset mid-burst: the burst is aborted immediately and no further writes occur. The block re-enters INIT and the array is re-cleared.
- Burst longer than DEPTH: wraps and overwrites or rereads; this is legal.

Optional Feature:
PARITY_EN
- Defined:
  - The array stores DATA_W+1 bits per word, with even parity computed on write. INIT writes parity 0.
  - On each read beat, an extra output ParityErr (1 bit, reset 0) is asserted alongside RdValid if the stored parity mismatches.
  - An extra input ParityInj (1 bit) inverts the stored parity bit on write beats, for test.
- Undefined: no ParityErr/ParityInj ports and the array is DATA_W bits wide.

Decomposition:
- Package burst_mem_ctrl_pkg holds:
  - state enum {INIT, IDLE, WRITE, READ};
  - the parity helper function.
- Sub-module burst_mem_array holds the DEPTH x (DATA_W[+1]) storage:
  - synchronous write;
  - registered synchronous read with one-cycle latency;
  - no reset on storage.
- The controller FSM, pointer and beat counter live in burst_mem_ctrl.

Test Plan:
- Reset release -> Busy=1 and Ready=0 for exactly 64 cycles. Reading 0x00..0x3F with BurstLen=15 (x4 commands) returns all zeros.
- Write Addr=0x05, BurstLen=3, data 0xA..A, 0xB..B, 0xC..C, 0xD..D, with WrValid low for 2 cycles mid-burst -> Done one cycle after the 4th beat. Read back of 0x05..0x08 returns the same data, with RdValid on T+2..T+5.
- Write Addr=0x3E, BurstLen=3 (data 1,2,3,4) -> Mem[0x3E]=1, Mem[0x3F]=2, Mem[0x00]=3, Mem[0x01]=4. A read burst from 0x3E confirms the wrap. Repeat with DEPTH=48, Addr=47: the next beat lands at 0.
- DEPTH=48, command with Addr=50 -> AddrErr and Done pulse together, no RdValid, array unchanged.
- Rst_n asserted mid-way through an 8-beat write -> outputs are at reset values immediately, INIT runs, and all words read 0.
- PARITY_EN: write with ParityInj=1 at Addr=0x10, then read it -> ParityErr=1 with RdValid. Without injection, ParityErr stays 0.
